// File: rtl/tis_port_channel.sv
// Rendezvous channel for one directed TIS-100 port link: the writer stalls until the
// reader has taken its word, and the reader stalls until a word has been delivered.
module tis_port_channel #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_stall,
    output logic             wr_done,
    input  logic             rd_req,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_stall,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StFull = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   buf_q, buf_d;
    logic [WIDTH-1:0]   rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        xfer_cnt_d = xfer_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (wr_req) begin
                    buf_d   = wr_data;
                    state_d = StFull;
                end
            end
            StFull: begin
                // An absent reader leaves the word latched and the writer stalled.
                if (rd_req) begin
                    rd_data_d  = buf_q;
                    rd_valid_d = 1'b1;
                    xfer_cnt_d = xfer_cnt_q + 1'b1;
                    state_d    = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            buf_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign wr_done  = (state_q == StDone);
    assign wr_stall = wr_req & (state_q != StDone);
    assign rd_stall = rd_req & ~rd_valid_q;
    assign busy     = (state_q != StIdle);
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_tis_port_channel.sv
// Bench for tis_port_channel: fixed vector table, directed handshake sequences and a
// randomized run, all checked against a queue-based rendezvous model.
module tb_tis_port_channel;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_req;
    logic [7:0] wr_data;
    logic       wr_stall;
    logic       wr_done;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_stall;
    logic       busy;
    logic [7:0] xfer_cnt;

    int n_vec = 0;
    int n_err = 0;

    tis_port_channel #(.WIDTH(8), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_req   (wr_req),
        .wr_data  (wr_data),
        .wr_stall (wr_stall),
        .wr_done  (wr_done),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_stall (rd_stall),
        .busy     (busy),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    // Model: a one-slot mailbox plus a "handing over" cycle after each delivery.
    logic [7:0] m_box[$];
    logic       m_handover;
    logic [7:0] m_rd_data;
    logic [7:0] m_cnt;

    task automatic model_reset();
        m_box.delete();
        m_handover = 1'b0;
        m_rd_data  = 8'h00;
        m_cnt      = 8'h00;
    endtask

    task automatic model_edge();
        if (m_handover) begin
            m_handover = 1'b0;
        end else if (m_box.size() == 0) begin
            if (wr_req) m_box.push_back(wr_data);
        end else if (rd_req) begin
            m_rd_data  = m_box.pop_front();
            m_cnt      = m_cnt + 8'd1;
            m_handover = 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("wr_stall", 32'(wr_stall), 32'(wr_req & ~m_handover));
        chk("wr_done", 32'(wr_done), 32'(m_handover));
        chk("rd_valid", 32'(rd_valid), 32'(m_handover));
        chk("rd_stall", 32'(rd_stall), 32'(rd_req & ~m_handover));
        chk("busy", 32'(busy), 32'(m_handover || (m_box.size() != 0)));
        chk("rd_data", 32'(rd_data), 32'(m_rd_data));
        chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    // Asynchronous reset pulse placed well away from any clock edge.
    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_model();
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        #2;
        reset = 1'b1;
    endtask

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] data;
        logic       e_wr_stall;
        logic       e_wr_done;
        logic       e_rd_valid;
        logic       e_rd_stall;
        logic       e_busy;
        logic [7:0] e_rd_data;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl[12];
    int   pulses;
    logic wrap_seen;
    logic [7:0] prev_cnt;

    initial begin
        //              wr  rd  data   wst wdn rv  rst bsy rdat   cnt
        tbl[0]  = '{1'b1, 1'b1, 8'h5A, 1, 0, 0, 1, 1, 8'h00, 8'd0};
        tbl[1]  = '{1'b1, 1'b1, 8'h5A, 0, 1, 1, 0, 1, 8'h5A, 8'd1};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 8'd1};
        tbl[3]  = '{1'b0, 1'b1, 8'h77, 0, 0, 0, 1, 0, 8'h5A, 8'd1};
        tbl[4]  = '{1'b1, 1'b1, 8'h77, 1, 0, 0, 1, 1, 8'h5A, 8'd1};
        tbl[5]  = '{1'b1, 1'b0, 8'h77, 1, 0, 0, 0, 1, 8'h5A, 8'd1};
        tbl[6]  = '{1'b1, 1'b1, 8'h99, 0, 1, 1, 0, 1, 8'h77, 8'd2};
        tbl[7]  = '{1'b1, 1'b1, 8'h99, 1, 0, 0, 1, 0, 8'h77, 8'd2};
        tbl[8]  = '{1'b1, 1'b1, 8'h99, 1, 0, 0, 1, 1, 8'h77, 8'd2};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 0, 0, 0, 0, 1, 8'h77, 8'd2};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 0, 1, 1, 0, 1, 8'h99, 8'd3};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 0, 0, 0, 0, 0, 8'h99, 8'd3};

        reset   = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        wr_data = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        #2;
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            wr_req  = tbl[i].wr;
            rd_req  = tbl[i].rd;
            wr_data = tbl[i].data;
            step();
            chk($sformatf("tbl%0d_wr_stall", i), 32'(wr_stall), 32'(tbl[i].e_wr_stall));
            chk($sformatf("tbl%0d_wr_done", i), 32'(wr_done), 32'(tbl[i].e_wr_done));
            chk($sformatf("tbl%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].e_rd_valid));
            chk($sformatf("tbl%0d_rd_stall", i), 32'(rd_stall), 32'(tbl[i].e_rd_stall));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].e_rd_data));
            chk($sformatf("tbl%0d_cnt", i), 32'(xfer_cnt), 32'(tbl[i].e_cnt));
        end

        // Writer first, reader arrives 10 cycles later.
        wr_req  = 1'b1;
        wr_data = 8'h80;
        step();
        for (int i = 0; i < 10; i++) begin
            wr_data = 8'(i * 17);
            step();
            chk("wf_wr_stall", 32'(wr_stall), 32'h1);
            chk("wf_busy", 32'(busy), 32'h1);
        end
        rd_req = 1'b1;
        step();
        chk("wf_rd_valid", 32'(rd_valid), 32'h1);
        chk("wf_wr_stall_done", 32'(wr_stall), 32'h0);
        chk("wf_rd_data", 32'(rd_data), 32'h80);
        wr_req = 1'b0;
        rd_req = 1'b0;
        step();

        // Reader first, writer arrives 6 cycles later.
        rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rf_rd_stall", 32'(rd_stall), 32'h1);
        end
        wr_req  = 1'b1;
        wr_data = 8'h01;
        step();
        chk("rf_rd_stall_full", 32'(rd_stall), 32'h1);
        step();
        chk("rf_rd_valid", 32'(rd_valid), 32'h1);
        chk("rf_rd_data", 32'(rd_data), 32'h01);
        wr_req = 1'b0;
        rd_req = 1'b0;
        step();

        // Reset while a word is held.
        wr_req  = 1'b1;
        wr_data = 8'h33;
        step();
        pulse_reset();
        wr_req = 1'b0;
        rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rs_rd_stall", 32'(rd_stall), 32'h1);
            chk("rs_rd_valid", 32'(rd_valid), 32'h0);
            chk("rs_wr_done", 32'(wr_done), 32'h0);
        end
        wr_req  = 1'b1;
        wr_data = 8'h44;
        step();
        step();
        chk("rs_rd_data", 32'(rd_data), 32'h44);
        wr_req = 1'b0;
        rd_req = 1'b0;
        step();

        // Both held high: one word per 3 cycles, counter wraps.
        wr_req    = 1'b1;
        rd_req    = 1'b1;
        pulses    = 0;
        wrap_seen = 1'b0;
        prev_cnt  = xfer_cnt;
        for (int i = 0; i < 768; i++) begin
            wr_data = 8'($urandom);
            step();
            if (rd_valid === 1'b1) pulses++;
            if (prev_cnt == 8'hFF && xfer_cnt == 8'h00) wrap_seen = 1'b1;
            prev_cnt = xfer_cnt;
        end
        chk("bb_pulses", 32'(pulses), 32'd256);
        chk("bb_wrap", 32'(wrap_seen), 32'h1);
        wr_req = 1'b0;
        rd_req = 1'b0;
        step();
        step();

        // Reader aborts mid-FULL, returns 4 cycles later.
        wr_req  = 1'b1;
        wr_data = 8'h3C;
        step();
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'($urandom);
            step();
            chk("ab_wr_stall", 32'(wr_stall), 32'h1);
            chk("ab_rd_valid", 32'(rd_valid), 32'h0);
        end
        rd_req = 1'b1;
        step();
        chk("ab_rd_valid_end", 32'(rd_valid), 32'h1);
        chk("ab_rd_data", 32'(rd_data), 32'h3C);
        wr_req = 1'b0;
        rd_req = 1'b0;
        step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            wr_req  = ($urandom_range(0, 3) != 0);
            rd_req  = ($urandom_range(0, 3) != 0);
            wr_data = 8'($urandom);
            step();
            if ($urandom_range(0, 63) == 0) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
